// File: rtl/tick_bcd_counter_pkg.sv
// Shared types and constants for the tick-gated BCD counter.
package tick_bcd_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Clamp a non-BCD nibble to 9.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_bcd_counter_digit.sv
// One BCD digit: clear > load > count, with carry/borrow out for chaining.
module bcd_digit
  import tick_bcd_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             cy_out
);

  logic [BCD_W-1:0] r_q;

  assign q = r_q;

  // Next digit steps only when this one rolls over in the counting direction.
  always_comb begin
    cy_out = en & (up_dn ? (r_q == BCD_MAX) : (r_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= bcd_sat(ld_val);
    end else if (en) begin
      if (up_dn) begin
        r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
      end else begin
        r_q <= (r_q == '0) ? BCD_MAX : r_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// Samples slow_clk into single-cycle ticks and gates them into a BCD up/down counter.
module tick_bcd_counter
  import tick_bcd_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        slow_clk,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clear,
  input  logic                        up_dn,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic                        tick,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        wrap,
  output logic                        running
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_slow_q;
  logic            r_tick;
  logic            r_wrap;
  logic            r_running;
  logic            w_cnt_en;
  logic            w_ld;
  logic [NUM_DIGITS:0] w_en;

  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign running = r_running;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // clear > stop > start; the unused code falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_nxt = ST_RUN;
        ST_RUN:   if (stop)  w_state_nxt = ST_PAUSE;
        ST_PAUSE: if (start) w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_en = 1'b0;
    w_ld     = 1'b0;
    if (!clear) begin
      w_cnt_en = (r_state == ST_RUN) & r_tick;
      w_ld     = load & ((r_state == ST_IDLE) | (r_state == ST_PAUSE));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slow_q  <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_slow_q  <= slow_clk;
      r_tick    <= slow_clk & ~r_slow_q;
      r_wrap    <= w_en[NUM_DIGITS];
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  assign w_en[0] = w_cnt_en;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .en     (w_en[i]),
      .up_dn  (up_dn),
      .ld     (w_ld),
      .ld_val (load_val[i*BCD_W +: BCD_W]),
      .clr    (clear),
      .q      (count[i*BCD_W +: BCD_W]),
      .cy_out (w_en[i+1])
    );
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Scoreboard bench for tick_bcd_counter using a decimal reference model.
module tb_tick_bcd_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        slow_clk = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        tick;
  logic [15:0] count;
  logic        wrap;
  logic        running;

  int n_checks = 0;
  int n_errors = 0;
  int ticks_seen = 0;
  int wraps_seen = 0;

  typedef struct packed {
    logic        tick;
    logic [15:0] count;
    logic        wrap;
    logic        running;
  } exp_t;

  exp_t q_exp[$];

  // Reference model state (decimal count).
  logic m_slow_q = 1'b0;
  logic m_tick = 1'b0;
  int   m_state = 0;
  int   m_cnt = 0;
  logic m_wrap = 1'b0;
  logic m_running = 1'b0;

  tick_bcd_counter #(.NUM_DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .count    (count),
    .wrap     (wrap),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_sat(input logic [15:0] b);
    int n;
    int w;
    int d;
    n = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) d = 9;
      n = n + d * w;
      w = w * 10;
    end
    return n;
  endfunction

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_edge();
    int  nxt;
    logic en;
    if (!rst) begin
      m_slow_q = 0; m_tick = 0; m_state = 0; m_cnt = 0; m_wrap = 0; m_running = 0;
      return;
    end
    en = (m_state == 1) && m_tick && !clear;
    m_wrap = 1'b0;
    if (clear) nxt = 0;
    else if (m_state == 1) nxt = stop ? 2 : 1;
    else if (m_state == 0) nxt = start ? 1 : 0;
    else nxt = start ? 1 : 2;
    if (clear) begin
      m_cnt = 0;
    end else if (load && m_state != 1) begin
      m_cnt = from_bcd_sat(load_val);
    end else if (en) begin
      if (up_dn) begin
        m_wrap = (m_cnt == 9999);
        m_cnt = (m_cnt + 1) % 10000;
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt = (m_cnt == 0) ? 9999 : m_cnt - 1;
      end
    end
    m_tick = slow_clk & ~m_slow_q;
    m_slow_q = slow_clk;
    m_state = nxt;
    m_running = (nxt == 1);
  endtask

  task automatic cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_edge();
      q_exp.push_back('{tick: m_tick, count: to_bcd(m_cnt), wrap: m_wrap, running: m_running});
      @(posedge clk);
      #1;
      if (q_exp.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = q_exp.pop_front();
        check("tick", 32'(tick), 32'(e.tick));
        check("count", 32'(count), 32'(e.count));
        check("wrap", 32'(wrap), 32'(e.wrap));
        check("running", 32'(running), 32'(e.running));
      end
      if (tick === 1'b1) ticks_seen++;
      if (wrap === 1'b1) wraps_seen++;
    end
  endtask

  task automatic rise();
    slow_clk = 1'b1; cyc(3);
    slow_clk = 1'b0; cyc(3);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  initial begin
    // Reset with slow_clk toggling.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_clk = ~slow_clk;
      cyc(1);
    end
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_running", 32'(running), 32'd0);
    slow_clk = 1'b0;
    rst = 1'b1;
    cyc(4);
    check("post_rst_count", 32'(count), 32'h0);
    check("post_rst_running", 32'(running), 32'd0);

    // Edge detect: long high, long low, high again.
    ticks_seen = 0;
    slow_clk = 1'b1; cyc(10);
    slow_clk = 1'b0; cyc(10);
    slow_clk = 1'b1; cyc(5);
    slow_clk = 1'b0; cyc(2);
    check("edge_ticks", 32'(ticks_seen), 32'd2);
    check("idle_no_count", 32'(count), 32'h0);

    // Up count to 12, then wrap from 9998.
    up_dn = 1'b1;
    pulse_start();
    for (int i = 0; i < 12; i++) rise();
    check("up12", 32'(count), 32'h0012);
    check("up12_running", 32'(running), 32'd1);
    pulse_stop();
    do_load(16'h9998);
    check("load9998", 32'(count), 32'h9998);
    wraps_seen = 0;
    pulse_start();
    rise();
    check("up9999", 32'(count), 32'h9999);
    rise();
    check("up_wrap_cnt", 32'(count), 32'h0000);
    check("up_wrap_once", 32'(wraps_seen), 32'd1);

    // Down count through zero.
    clear = 1'b1; cyc(1); clear = 1'b0;
    do_load(16'h0001);
    up_dn = 1'b0;
    wraps_seen = 0;
    pulse_start();
    rise();
    check("dn0000", 32'(count), 32'h0000);
    rise();
    check("dn9999", 32'(count), 32'h9999);
    check("dn_wrap_once", 32'(wraps_seen), 32'd1);

    // clear coinciding with a tick at 9999 counting up.
    up_dn = 1'b1;
    wraps_seen = 0;
    slow_clk = 1'b1; cyc(1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    slow_clk = 1'b0; cyc(2);
    check("clr_tick_cnt", 32'(count), 32'h0);
    check("clr_tick_run", 32'(running), 32'd0);
    check("clr_tick_nowrap", 32'(wraps_seen), 32'd0);

    // stop coinciding with a tick at 0005.
    do_load(16'h0005);
    pulse_start();
    slow_clk = 1'b1; cyc(1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    slow_clk = 1'b0; cyc(2);
    check("stop_tick_cnt", 32'(count), 32'h0006);
    check("stop_tick_run", 32'(running), 32'd0);

    // Load saturation in PAUSE, load ignored in RUN.
    do_load(16'h0A3F);
    check("load_sat", 32'(count), 32'h0939);
    pulse_start();
    do_load(16'h1234);
    cyc(1);
    check("load_in_run", 32'(count), 32'h0939);

    // Reset mid-run.
    pulse_stop();
    do_load(16'h0041);
    pulse_start();
    rise();
    check("pre_rst42", 32'(count), 32'h0042);
    rst = 1'b0; cyc(1); rst = 1'b1;
    check("midrun_rst_cnt", 32'(count), 32'h0);
    check("midrun_rst_run", 32'(running), 32'd0);
    cyc(3);
    check("after_rst_idle", 32'(running), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the divider's slow_clk; stays entirely in the fast clk domain (slow_clk is sampled, never used as a clock).
- Detects rising edges of slow_clk and turns each one into a single-cycle tick.
- A start/stop/clear FSM gates the ticks into a NUM_DIGITS-digit BCD up/down counter that feeds the display logic.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; count width = 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock; same clock that drives the divider.
- rst  input  1  reset, synchronous, active-low (0 = reset), sampled on posedge clk.
- slow_clk  input  1  divider output; level toggles, registered in the clk domain.
- start  input  1  level or pulse; IDLE/PAUSE -> RUN.
- stop  input  1  RUN -> PAUSE.
- clear  input  1  any state -> IDLE, count = 0.
- up_dn  input  1  1 = count up, 0 = count down; sampled on each counted tick.
- load  input  1  load load_val; honoured in IDLE or PAUSE only.
- load_val  input  4*NUM_DIGITS  BCD preload value; digit 0 is bits [3:0].
- tick  output  1  one-cycle pulse per slow_clk rising edge.
- count  output  4*NUM_DIGITS  BCD count value, digit 0 least significant.
- wrap  output  1  one-cycle pulse on roll-over (all 9s -> 0 up, or 0 -> all 9s down).
- running  output  1  high when the FSM is in RUN.

Behaviour:
- Reset (rst==0 at posedge clk):
  - slow_q=0, state=IDLE, count=0, tick=0, wrap=0, running=0.
  - Reset overrides every other input, including mid-count.
- Edge detect, all registered:
  - slow_q <= slow_clk; tick <= slow_clk & ~slow_q.
  - Exactly one tick per 0->1 transition of slow_clk. A level held high or low never produces a tick. Falling edges are ignored.
  - Latency: tick is high in the cycle after the first clk edge that samples slow_clk=1.
- FSM states and encodings: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2. Code 3 is illegal and recovers to IDLE.
  - Transitions, evaluated in priority order clear > stop > start:
    - IDLE + start -> RUN.
    - RUN + stop -> PAUSE.
    - PAUSE + start -> RUN.
    - Any state + clear -> IDLE with count=0.
  - stop in IDLE or PAUSE has no effect. start in RUN has no effect.
- Counting:
  - On an edge where state==RUN and tick==1, count updates at that edge. Slow edge to count change is 2 clk cycles.
  - A tick arriving in the same cycle as the start that leaves IDLE is not counted.
- BCD arithmetic:
  - Up: digit 9 -> 0 with carry into the next digit; otherwise +1.
  - Down: digit 0 -> 9 with borrow into the next digit; otherwise -1.
  - The full-width wrap raises wrap for exactly the cycle after the update. wrap=0 at all other times.
- Load:
  - In IDLE or PAUSE, load=1 sets count <= load_val at the next edge.
  - Any digit >9 in load_val is saturated to 9 per digit.
  - load in RUN is ignored.
  - clear beats load. load does not change state.
- Simultaneous events:
  - clear + tick in RUN: count=0, no increment, no wrap.
  - stop + tick in RUN: the tick is counted and the state goes to PAUSE.
- running is registered and equals (state==RUN) after each edge.

Decomposition:
- Shared package/header holds:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE.
  - BCD_MAX=4'd9 and BCD_W=4.
- Sub-module bcd_digit:
  - Ports: clk, rst, en, up_dn, ld, ld_val[3:0], clr, q[3:0], cy_out (carry/borrow out; combinational from q, en, up_dn).
  - Instantiated NUM_DIGITS times in a generate loop, with each cy_out chained into the next digit's en.
- The top level holds the edge detect, the FSM and the wrap/running registers.

Test Plan:
- Reset: drive rst=0 for 3 cycles with slow_clk toggling -> tick=0, count=0, running=0, wrap=0; release -> still IDLE, no count change.
- Edge detect: hold slow_clk high for 10 cycles, then low for 10, then high -> exactly 2 tick pulses, each 1 cycle wide, each 1 cycle after the rise is sampled.
- Up count: start, up_dn=1, 12 slow rises -> count=16'h0012; load 16'h9998 in PAUSE, resume, 2 rises -> count=16'h0000 with wrap high for 1 cycle on the second.
- Down count: in IDLE load 16'h0001, start, up_dn=0, 2 rises -> 16'h0000 then 16'h9999 with wrap pulsed once.
- Priority: in RUN, assert clear in the same cycle as tick -> count=0, state IDLE, no wrap. In RUN, assert stop with tick at count 16'h0005 -> count=16'h0006, running=0.
- Load rules: load 16'h0A3F in PAUSE -> count=16'h0939. Load in RUN -> count unchanged. Assert rst=0 mid-RUN at count 16'h0042 -> count=0, IDLE next cycle.
